// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial (N+1)-bit minus N-bit subtractor with START/BUSY/DONE handshake
// Optional feature macro: SERIAL_SUBTRACTOR_STICKY_ERR_EN (ERR stays set across completions until RST).
// N must be at least 2.

module serial_subtractor #(
  parameter int N = 6
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N:0]   S,
  input  logic [N-1:0] B,
  output logic [N-1:0] A,
  output logic         ERR,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    sr_q, sr_d;     // minuend shift register, LSB consumed first
  logic [N:0]    br_q, br_d;     // subtrahend, zero-extended to N+1 bits
  logic [N-1:0]  d_q, d_d;       // difference bits 0..N-1, filled from the top
  logic [N-1:0]  a_q, a_d;
  logic          bw_q, bw_d;     // running borrow
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic s_bit;
  logic b_bit;
  logic diff_bit;
  logic borrow_next;
  logic last_bit;
  logic new_err;
  logic err_result;

  // Single full-subtractor cell operating on the current LSBs plus the borrow register.
  always_comb begin
    s_bit       = sr_q[0];
    b_bit       = br_q[0];
    diff_bit    = s_bit ^ b_bit ^ bw_q;
    borrow_next = (~s_bit & b_bit) | (~(s_bit ^ b_bit) & bw_q);
    last_bit    = (cnt_q == CW'(N));
    // Final borrow means negative; difference bit N set means the result exceeds N bits.
    new_err     = borrow_next | diff_bit;
`ifdef SERIAL_SUBTRACTOR_STICKY_ERR_EN
    err_result  = err_q | new_err;
`else
    err_result  = new_err;
`endif
  end

  // Next-state and datapath update: everything holds unless the FSM says otherwise.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    br_d    = br_q;
    d_d     = d_q;
    a_d     = a_q;
    bw_d    = bw_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          sr_d    = S;
          br_d    = {1'b0, B};
          d_d     = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sr_d  = {1'b0, sr_q[N:1]};
        br_d  = {1'b0, br_q[N:1]};
        d_d   = {diff_bit, d_q[N-1:1]};
        bw_d  = borrow_next;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          // d_q already holds bits 0..N-1; the bit computed now is bit N.
          a_d     = d_q;
          err_d   = err_result;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset that discards any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      br_q    <= '0;
      d_q     <= '0;
      a_q     <= '0;
      bw_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      d_q     <= d_d;
      a_q     <= a_d;
      bw_q    <= bw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A    = a_q;
  assign ERR  = err_q;
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed table-driven and sweep bench for serial_subtractor

module tb_serial_subtractor;

  localparam int N = 6;
  localparam int MAXV = (1 << N) - 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [N:0]   S;
  logic [N-1:0] B;
  logic [N-1:0] A;
  logic         ERR;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;
  logic sticky_acc = 1'b0;

  typedef struct {
    int s;
    int b;
    int exp_a;
    int exp_err;
  } vec_t;

  vec_t vecs [12];

  serial_subtractor #(.N(N)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .S    (S),
    .B    (B),
    .A    (A),
    .ERR  (ERR),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected ERR after a completion, including the sticky behaviour when enabled.
  function automatic int eff_err(input int raw);
`ifdef SERIAL_SUBTRACTOR_STICKY_ERR_EN
    sticky_acc = sticky_acc | raw[0];
    return int'(sticky_acc);
`else
    return raw;
`endif
  endfunction

  task automatic do_reset();
    RST   = 1'b1;
    START = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    sticky_acc = 1'b0;
  endtask

  // Launch one subtraction and check handshake timing plus result.
  // poke raises START during RUN and during FIN; neither may start a new operation.
  task automatic run_op(input int s, input int b, input int exp_a, input int exp_err_raw,
                        input bit poke, input string tag);
    bit timing_ok;
    int exp_err;
    exp_err = eff_err(exp_err_raw);
    S     = s[N:0];
    B     = b[N-1:0];
    START = 1'b1;
    tick();                       // accepting edge k
    START = 1'b0;
    S     = ~S;
    B     = ~B;
    timing_ok = 1'b1;
    for (int j = 0; j <= N; j++) begin
      if (!(BUSY === 1'b1 && DONE === 1'b0)) timing_ok = 1'b0;
      if (poke && j == 2) START = 1'b1;
      if (poke && j == 3) START = 1'b0;
      tick();
    end
    // now after edge k+N+1
    if (!(DONE === 1'b1 && BUSY === 1'b0)) timing_ok = 1'b0;
    check({tag, "_a"}, 32'(A), 32'(exp_a));
    check({tag, "_err"}, 32'(ERR), 32'(exp_err));
    if (poke) START = 1'b1;
    tick();                       // edge k+N+2, back to IDLE
    if (DONE !== 1'b0) timing_ok = 1'b0;
    if (poke) begin
      START = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (BUSY !== 1'b0 || DONE !== 1'b0) timing_ok = 1'b0;
      end
      check({tag, "_a_hold"}, 32'(A), 32'(exp_a));
    end
    check({tag, "_timing"}, 32'(timing_ok), 32'd1);
  endtask

  initial begin
    bit no_done;

    vecs[0]  = '{s: 100, b: 37, exp_a: 63, exp_err: 0};
    vecs[1]  = '{s: 5,   b: 9,  exp_a: 60, exp_err: 1};
    vecs[2]  = '{s: 127, b: 0,  exp_a: 63, exp_err: 1};
    vecs[3]  = '{s: 64,  b: 1,  exp_a: 63, exp_err: 0};
    vecs[4]  = '{s: 0,   b: 0,  exp_a: 0,  exp_err: 0};
    vecs[5]  = '{s: 0,   b: 63, exp_a: 1,  exp_err: 1};
    vecs[6]  = '{s: 63,  b: 63, exp_a: 0,  exp_err: 0};
    vecs[7]  = '{s: 127, b: 63, exp_a: 0,  exp_err: 1};
    vecs[8]  = '{s: 64,  b: 0,  exp_a: 0,  exp_err: 1};
    vecs[9]  = '{s: 126, b: 63, exp_a: 63, exp_err: 0};
    vecs[10] = '{s: 42,  b: 21, exp_a: 21, exp_err: 0};
    vecs[11] = '{s: 1,   b: 2,  exp_a: 63, exp_err: 1};

    RST   = 1'b1;
    START = 1'b0;
    S     = '0;
    B     = '0;
    do_reset();
    check("reset_a",    32'(A),    32'd0);
    check("reset_err",  32'(ERR),  32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);

    // Table of directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].s, vecs[i].b, vecs[i].exp_a, vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));
    end

    // START during BUSY and FIN is ignored; operands were latched at acceptance
    do_reset();
    run_op(10, 3, 7, 0, 1'b1, "poke");

    // Reset in the 3rd RUN cycle discards the operation
    S     = 7'd50;
    B     = 6'd20;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sticky_acc = 1'b0;
    check("midrst_a",    32'(A),    32'd0);
    check("midrst_err",  32'(ERR),  32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    no_done = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (DONE !== 1'b0 || BUSY !== 1'b0) no_done = 1'b0;
      tick();
    end
    check("midrst_no_done", 32'(no_done), 32'd1);
    run_op(50, 20, 30, 0, 1'b0, "after_rst");

    // RST wins over START on the same edge
    RST   = 1'b1;
    START = 1'b1;
    S     = 7'd10;
    B     = 6'd3;
    tick();
    RST   = 1'b0;
    START = 1'b0;
    sticky_acc = 1'b0;
    check("rst_prio_busy", 32'(BUSY), 32'd0);
    tick();
    check("rst_prio_busy2", 32'(BUSY), 32'd0);

    // Exhaustive sweep against the arithmetic reference
    do_reset();
    for (int s = 0; s <= 2 * MAXV + 1; s++) begin
      for (int b = 0; b <= MAXV; b++) begin
        run_op(s, b, (s - b) & MAXV, ((s < b) || (s - b > MAXV)) ? 1 : 0, 1'b0,
               $sformatf("sweep_s%0d_b%0d", s, b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
